// File: rtl/sh7604_ibus_arb.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : sh7604_ibus_arb
// Description : Internal-bus arbiter between the CPU core and the DMAC of an
//               SH7604-style device. It merges the two access ports onto one
//               request towards the bus state controller. Ownership changes
//               only at switch points, so locked and burst accesses are not
//               split.
// Revision    : 1.0 - initial release
// ============================================================================
module sh7604_ibus_arb #(
  parameter int RR       = 1,  // 1: round-robin, 0: DMAC has fixed priority
  parameter int MAX_HOLD = 4   // grant windows kept while the other side waits
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_r_i,
  input  logic        ce_f_i,
  input  logic        en_i,
  // CPU access port
  input  logic [31:0] cpu_a_i,
  input  logic [31:0] cpu_di_i,
  input  logic [3:0]  cpu_ba_i,
  input  logic        cpu_we_i,
  input  logic        cpu_req_i,
  input  logic        cpu_burst_i,
  input  logic        cpu_lock_i,
  output logic [31:0] cpu_do_o,
  output logic        cpu_busy_o,
  // DMAC access port
  input  logic [31:0] dma_a_i,
  input  logic [31:0] dma_di_i,
  input  logic [3:0]  dma_ba_i,
  input  logic        dma_we_i,
  input  logic        dma_req_i,
  input  logic        dma_burst_i,
  input  logic        dma_lock_i,
  output logic [31:0] dma_do_o,
  output logic        dma_busy_o,
  // Merged request towards the bus state controller
  output logic [31:0] ibus_a_o,
  output logic [31:0] ibus_di_o,
  output logic [3:0]  ibus_ba_o,
  output logic        ibus_we_o,
  output logic        ibus_req_o,
  output logic        ibus_burst_o,
  output logic        ibus_lock_o,
  input  logic [31:0] ibus_do_i,
  input  logic        ibus_busy_i,
  // Current owner: 00 none, 01 CPU, 10 DMAC
  output logic [1:0]  gnt_o
);

  // Encoding matches the GNT output so the grant is a direct copy of state.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);
  localparam logic [3:0] C_HOLD_SAT = 4'd15;

  owner_e     owner_q;
  owner_e     last_q;
  logic [3:0] hold_cnt_q;

  // Arbitration result used when the bus is idle and both masters request.
  owner_e     pick_d;
  // Saturating increment of the hold counter.
  logic [3:0] hold_inc_d;

  logic own_cpu;
  logic own_dma;
  logic owner_req;
  logic owner_lock;
  logic other_req;
  logic owner_yield;
  logic switch_pt;

  // The falling-phase enable has no role here: all state moves on CE_R.
  logic unused_ce_f;
  assign unused_ce_f = ce_f_i;

  assign own_cpu = (owner_q == OWN_CPU);
  assign own_dma = (owner_q == OWN_DMA);

  // Owner-side request/lock and the competing request, zero when idle.
  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    other_req  = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        owner_req  = cpu_req_i;
        owner_lock = cpu_lock_i;
        other_req  = dma_req_i;
      end
      OWN_DMA: begin
        owner_req  = dma_req_i;
        owner_lock = dma_lock_i;
        other_req  = cpu_req_i;
      end
      default: begin
        owner_req  = 1'b0;
        owner_lock = 1'b0;
        other_req  = 1'b0;
      end
    endcase
  end

  // A busy bus blocks switching, which also keeps an in-flight burst
  // (IBUS_BURST=1 with IBUS_BUSY=1) under a single owner; a locked owner
  // blocks switching so read-modify-write sequences stay atomic.
  assign switch_pt = ce_r_i & en_i & ~ibus_busy_i & ~owner_lock;

  assign hold_inc_d = (hold_cnt_q == C_HOLD_SAT) ? C_HOLD_SAT : hold_cnt_q + 4'd1;

  generate
    if (RR != 0) begin : g_round_robin
      // Both requesting: favour the master that did not own the bus last.
      assign pick_d = (cpu_req_i && dma_req_i) ?
                      ((last_q == OWN_CPU) ? OWN_DMA : OWN_CPU) :
                      (dma_req_i ? OWN_DMA : OWN_CPU);
      // Round-robin gives up the bus only on the hold limit.
      assign owner_yield = 1'b0;
    end else begin : g_fixed_prio
      // DMAC always wins a tie.
      assign pick_d = dma_req_i ? OWN_DMA : OWN_CPU;
      // A CPU owner steps aside as soon as the DMAC asks.
      assign owner_yield = own_cpu;
    end
  endgenerate

  // Ownership, round-robin history and hold counter, advanced at switch points.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      last_q     <= OWN_CPU;
      hold_cnt_q <= 4'd0;
    end else if (switch_pt) begin
      case (owner_q)
        OWN_NONE: begin
          if (cpu_req_i || dma_req_i) begin
            owner_q    <= pick_d;
            hold_cnt_q <= 4'd1;
          end
        end
        default: begin
          if (!owner_req) begin
            // Release only; the next grant waits for the following switch
            // point so there is always one idle window between owners.
            owner_q    <= OWN_NONE;
            last_q     <= owner_q;
            hold_cnt_q <= 4'd0;
          end else if (other_req) begin
            if ((hold_cnt_q >= C_MAX_HOLD) || owner_yield) begin
              owner_q    <= OWN_NONE;
              last_q     <= owner_q;
              hold_cnt_q <= 4'd0;
            end else begin
              hold_cnt_q <= hold_inc_d;
            end
          end
        end
      endcase
    end
  end

  // Merged bus request: the owner's signals, all zero while nobody owns it.
  always_comb begin
    ibus_a_o     = 32'd0;
    ibus_di_o    = 32'd0;
    ibus_ba_o    = 4'd0;
    ibus_we_o    = 1'b0;
    ibus_req_o   = 1'b0;
    ibus_burst_o = 1'b0;
    ibus_lock_o  = 1'b0;
    if (own_cpu) begin
      ibus_a_o     = cpu_a_i;
      ibus_di_o    = cpu_di_i;
      ibus_ba_o    = cpu_ba_i;
      ibus_we_o    = cpu_we_i;
      ibus_req_o   = cpu_req_i;
      ibus_burst_o = cpu_burst_i;
      ibus_lock_o  = cpu_lock_i;
    end else if (own_dma) begin
      ibus_a_o     = dma_a_i;
      ibus_di_o    = dma_di_i;
      ibus_ba_o    = dma_ba_i;
      ibus_we_o    = dma_we_i;
      ibus_req_o   = dma_req_i;
      ibus_burst_o = dma_burst_i;
      ibus_lock_o  = dma_lock_i;
    end
  end

  // The owner sees the controller's wait; a waiting master is stalled by
  // its own request in the same cycle it raises it.
  assign cpu_busy_o = own_cpu ? ibus_busy_i : cpu_req_i;
  assign dma_busy_o = own_dma ? ibus_busy_i : dma_req_i;

  // Read data is broadcast; only the current owner samples it.
  assign cpu_do_o = ibus_do_i;
  assign dma_do_o = ibus_do_i;

  assign gnt_o = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_sh7604_ibus_arb.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_sh7604_ibus_arb
// Description : Scoreboard bench for sh7604_ibus_arb. Two instances share the
//               stimulus: one round-robin, one fixed-priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sh7604_ibus_arb;

  localparam logic [31:0] C_CPU_A = 32'h0000_0100;
  localparam logic [31:0] C_DMA_A = 32'h0000_0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce_r, ce_f, en;
  logic        cpu_req, cpu_lock, cpu_burst;
  logic        dma_req, dma_lock, dma_burst;
  logic        ibus_busy;
  logic [31:0] ibus_do;

  // Round-robin instance outputs
  logic [31:0] rr_cpu_do, rr_dma_do, rr_a, rr_di;
  logic        rr_cpu_busy, rr_dma_busy, rr_we, rr_req, rr_burst, rr_lock;
  logic [3:0]  rr_ba;
  logic [1:0]  rr_gnt;
  // Fixed-priority instance outputs
  logic [31:0] fp_cpu_do, fp_dma_do, fp_a, fp_di;
  logic        fp_cpu_busy, fp_dma_busy, fp_we, fp_req, fp_burst, fp_lock;
  logic [3:0]  fp_ba;
  logic [1:0]  fp_gnt;

  sh7604_ibus_arb #(.RR(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .ce_r_i(ce_r), .ce_f_i(ce_f), .en_i(en),
    .cpu_a_i(C_CPU_A), .cpu_di_i(32'h1111_1111), .cpu_ba_i(4'hF), .cpu_we_i(1'b1),
    .cpu_req_i(cpu_req), .cpu_burst_i(cpu_burst), .cpu_lock_i(cpu_lock),
    .cpu_do_o(rr_cpu_do), .cpu_busy_o(rr_cpu_busy),
    .dma_a_i(C_DMA_A), .dma_di_i(32'h2222_2222), .dma_ba_i(4'h3), .dma_we_i(1'b0),
    .dma_req_i(dma_req), .dma_burst_i(dma_burst), .dma_lock_i(dma_lock),
    .dma_do_o(rr_dma_do), .dma_busy_o(rr_dma_busy),
    .ibus_a_o(rr_a), .ibus_di_o(rr_di), .ibus_ba_o(rr_ba), .ibus_we_o(rr_we),
    .ibus_req_o(rr_req), .ibus_burst_o(rr_burst), .ibus_lock_o(rr_lock),
    .ibus_do_i(ibus_do), .ibus_busy_i(ibus_busy), .gnt_o(rr_gnt)
  );

  sh7604_ibus_arb #(.RR(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .ce_r_i(ce_r), .ce_f_i(ce_f), .en_i(en),
    .cpu_a_i(C_CPU_A), .cpu_di_i(32'h1111_1111), .cpu_ba_i(4'hF), .cpu_we_i(1'b1),
    .cpu_req_i(cpu_req), .cpu_burst_i(cpu_burst), .cpu_lock_i(cpu_lock),
    .cpu_do_o(fp_cpu_do), .cpu_busy_o(fp_cpu_busy),
    .dma_a_i(C_DMA_A), .dma_di_i(32'h2222_2222), .dma_ba_i(4'h3), .dma_we_i(1'b0),
    .dma_req_i(dma_req), .dma_burst_i(dma_burst), .dma_lock_i(dma_lock),
    .dma_do_o(fp_dma_do), .dma_busy_o(fp_dma_busy),
    .ibus_a_o(fp_a), .ibus_di_o(fp_di), .ibus_ba_o(fp_ba), .ibus_we_o(fp_we),
    .ibus_req_o(fp_req), .ibus_burst_o(fp_burst), .ibus_lock_o(fp_lock),
    .ibus_do_i(ibus_do), .ibus_busy_i(ibus_busy), .gnt_o(fp_gnt)
  );

  typedef struct {
    string       nm;
    int          d;      // 0: round-robin instance, 1: fixed-priority
    logic [1:0]  gnt;
    logic        req;
    logic        cb;
    logic        db;
    logic [31:0] a;
    logic [31:0] cdo;
    logic [31:0] ddo;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  event chk_ev;

  // Hand-derived grant sequences with both masters requesting continuously.
  logic [1:0] rr_seq [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
  logic [1:0] fp_seq [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};

  // Expected response given the grant: owner sees the bus, waiter sees its REQ.
  task automatic expect_g(input int d, input string nm, input logic [1:0] g);
    exp_t e;
    e.nm  = nm;
    e.d   = d;
    e.gnt = g;
    e.req = (g == 2'b01) ? cpu_req : (g == 2'b10) ? dma_req : 1'b0;
    e.cb  = (g == 2'b01) ? ibus_busy : cpu_req;
    e.db  = (g == 2'b10) ? ibus_busy : dma_req;
    e.a   = (g == 2'b01) ? C_CPU_A : (g == 2'b10) ? C_DMA_A : 32'd0;
    e.cdo = ibus_do;
    e.ddo = ibus_do;
    q.push_back(e);
  endtask

  task automatic both(input string nm, input logic [1:0] g);
    expect_g(0, nm, g);
    expect_g(1, nm, g);
  endtask

  task automatic check_now();
    ->chk_ev;
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    dma_req   = 1'b0;
    cpu_lock  = 1'b0;
    dma_lock  = 1'b0;
    cpu_burst = 1'b0;
    dma_burst = 1'b0;
    ibus_busy = 1'b0;
    en        = 1'b1;
    ce_r      = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the addressed DUT.
  initial begin : mon
    exp_t        e;
    logic [1:0]  ag;
    logic        areq, acb, adb;
    logic [31:0] aa, acdo, addo;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.d == 0) begin
          ag = rr_gnt; areq = rr_req; acb = rr_cpu_busy; adb = rr_dma_busy;
          aa = rr_a; acdo = rr_cpu_do; addo = rr_dma_do;
        end else begin
          ag = fp_gnt; areq = fp_req; acb = fp_cpu_busy; adb = fp_dma_busy;
          aa = fp_a; acdo = fp_cpu_do; addo = fp_dma_do;
        end
        n_run++;
        if (ag !== e.gnt || areq !== e.req || acb !== e.cb || adb !== e.db ||
            aa !== e.a || acdo !== e.cdo || addo !== e.ddo) begin
          n_fail++;
          $display("FAIL %s dut%0d: got gnt=%b req=%b cbusy=%b dbusy=%b a=%h cdo=%h ddo=%h, expected gnt=%b req=%b cbusy=%b dbusy=%b a=%h cdo=%h ddo=%h",
                   e.nm, e.d, ag, areq, acb, adb, aa, acdo, addo,
                   e.gnt, e.req, e.cb, e.db, e.a, e.cdo, e.ddo);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0; en = 1'b1;
    cpu_req = 1'b0; cpu_lock = 1'b0; cpu_burst = 1'b0;
    dma_req = 1'b0; dma_lock = 1'b0; dma_burst = 1'b0;
    ibus_busy = 1'b0; ibus_do = 32'hCAFE_0001;

    // Reset state and first CPU grant
    cpu_req = 1'b1;
    #3;
    both("rst_idle", 2'b00);
    check_now();
    rst_n = 1'b1;
    edge_(); both("cpu_first_grant", 2'b01); check_now();
    ibus_busy = 1'b1;
    edge_(); both("cpu_wait", 2'b01); check_now();
    ibus_busy = 1'b0; cpu_req = 1'b0; ce_r = 1'b0;
    edge_(); both("ce_r_low_hold", 2'b01); check_now();
    ce_r = 1'b1;
    edge_(); both("cpu_release", 2'b00); check_now();

    // Tie from idle, release gap, fixed-priority CPU yield
    cpu_req = 1'b1; dma_req = 1'b1;
    edge_(); both("tie_from_idle", 2'b10); check_now();
    edge_(); both("dma_keep", 2'b10); check_now();
    dma_req = 1'b0;
    edge_(); both("dma_release_gap", 2'b00); check_now();
    edge_(); both("cpu_after_gap", 2'b01); check_now();
    dma_req = 1'b1;
    edge_(); expect_g(0, "rr_cpu_hold", 2'b01); expect_g(1, "fp_cpu_yield", 2'b00); check_now();
    edge_(); expect_g(0, "rr_cpu_hold2", 2'b01); expect_g(1, "fp_dma_regrant", 2'b10); check_now();

    // Continuous contention: 4-window bursts with one idle window between
    do_reset();
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge_();
      expect_g(0, $sformatf("rr_rot%0d", i), rr_seq[i]);
      expect_g(1, $sformatf("fp_prio%0d", i), fp_seq[i]);
      check_now();
    end

    // Locked CPU access holds the bus against a waiting DMAC
    do_reset();
    cpu_req = 1'b1;
    edge_(); both("lock_grant", 2'b01); check_now();
    cpu_lock = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_(); both($sformatf("lock_hold%0d", i), 2'b01); check_now();
    end
    cpu_lock = 1'b0; cpu_req = 1'b0;
    edge_(); both("unlock_release", 2'b00); check_now();
    edge_(); both("dma_after_lock", 2'b10); check_now();

    // DMAC burst in flight: no switch while the bus is busy
    dma_burst = 1'b1; ibus_busy = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dma_req = (i == 0);
      edge_(); both($sformatf("burst_hold%0d", i), 2'b10); check_now();
    end
    ibus_busy = 1'b0;
    edge_(); both("burst_end_release", 2'b00); check_now();
    edge_(); both("cpu_after_burst", 2'b01); check_now();

    // Asynchronous abort of a DMAC grant
    do_reset();
    dma_req = 1'b1;
    edge_(); both("dma_grant", 2'b10); check_now();
    cpu_req = 1'b1;
    rst_n = 1'b0;
    #1;
    both("async_abort", 2'b00);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;

    // Freeze with EN=0: grant and hold count must not move
    cpu_req = 1'b0;
    edge_(); both("dma_regrant", 2'b10); check_now();
    cpu_req = 1'b1;
    edge_(); both("dma_hold2", 2'b10); check_now();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_(); both($sformatf("en_freeze%0d", i), 2'b10); check_now();
    end
    en = 1'b1;
    edge_(); both("dma_hold3", 2'b10); check_now();
    edge_(); both("dma_hold4", 2'b10); check_now();
    edge_(); both("hold_limit_release", 2'b00); check_now();
    edge_(); expect_g(0, "rr_cpu_turn", 2'b01); expect_g(1, "fp_dma_again", 2'b10); check_now();

    #2;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sh7604_ibus_arb.md
SH7604_IBUS_ARB -- requirements
Module: SH7604_IBUS_ARB

Interface
REQ-001 Parameter RR, default 1: 1 = round-robin between CPU and DMAC; 0 = fixed priority, DMAC over CPU.
REQ-002 Parameter MAX_HOLD, default 4 (range 1..15): maximum consecutive grant windows held by one master while the other is requesting.
REQ-003 CLK  in  1  single clock for the whole block.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 CE_R, CE_F  in  1 each  rising/falling-phase clock enables; all state changes occur only on CE_R.
REQ-006 EN  in  1  state freeze when 0.
REQ-007 CPU_A/DI in 32 each; CPU_BA in 4; CPU_WE/REQ/BURST/LOCK in 1 each: CPU-side access.
REQ-008 CPU_DO  out  32  read data; CPU_BUSY  out  1  CPU wait.
REQ-009 DMA_A/DI/BA/WE/REQ/BURST/LOCK: DMAC-side access, same widths as CPU; DMA_DO out 32, DMA_BUSY out 1.
REQ-010 IBUS_A out 32, IBUS_DI out 32, IBUS_BA out 4, IBUS_WE/REQ/BURST/LOCK out 1 each: merged request to the bus state controller.
REQ-011 IBUS_DO in 32, IBUS_BUSY in 1: data and wait returned by the bus state controller.
REQ-012 GNT  out  2  current owner: 00 none, 01 CPU, 10 DMAC; 11 never driven.

Function
REQ-013 Registered state: OWNER (NONE/CPU/DMA), LAST (last owner, for round-robin), HOLD_CNT (4 bits).
REQ-014 IBUS_A/DI/BA/WE/BURST/LOCK are combinational muxes of the owner's signals; they are 0 when OWNER=NONE.
REQ-015 IBUS_REQ is the owner's REQ; it is 0 when OWNER=NONE.
REQ-016 The owner's BUSY is IBUS_BUSY; the non-owner's BUSY is its own REQ, so a waiting master is stalled in the same cycle it requests.
REQ-017 CPU_DO and DMA_DO are both driven with IBUS_DO; only the owner samples it.
REQ-018 A switch point is a CE_R with EN=1, IBUS_BUSY=0, and owner LOCK=0.
REQ-019 At a switch point with OWNER=NONE: grant the sole requester; if both request, RR=0 grants DMA, RR=1 grants the master other than LAST; HOLD_CNT <= 1.
REQ-020 At a switch point when the owner's REQ=0: OWNER <= NONE, LAST <= owner, HOLD_CNT <= 0.
REQ-021 Re-arbitration on a release cycle is not allowed; the new grant occurs at the next switch point, giving one idle CE_R between owners.
REQ-022 At a switch point when the owner's REQ=1 and the other master requests: if HOLD_CNT >= MAX_HOLD, or RR=0 with owner=CPU, then OWNER <= NONE and LAST <= owner; otherwise HOLD_CNT <= HOLD_CNT+1, saturating at 15.
REQ-023 At a switch point when the owner's REQ=1 and the other master does not request: the owner is kept and HOLD_CNT is unchanged.
REQ-024 While the owner's LOCK=1, OWNER never changes, regardless of HOLD_CNT or priority; this covers atomic read-modify-write.
REQ-025 While IBUS_BURST=1 and IBUS_BUSY=1, OWNER never changes, so a burst completes under one owner.
REQ-026 EN=0 or CE_R=0: all registers hold; the combinational paths stay live.
REQ-027 GNT mirrors OWNER.

Reset
REQ-028 RST_N=0 sets OWNER=NONE, LAST=CPU, HOLD_CNT=0 immediately; GNT=00 and IBUS_REQ=0.
REQ-029 During reset, each master's BUSY equals its REQ.
REQ-030 Reset during an owned access aborts the grant; IBUS_REQ drops asynchronously.

Verification
REQ-031 Reset, then CPU_REQ=1, CPU_A=0x00000100, IBUS_BUSY=0 -> GNT=01 at the first CE_R; IBUS_A=0x00000100; CPU_BUSY follows IBUS_BUSY.
REQ-032 RR=0, CPU and DMA requesting from idle -> GNT=10 and CPU_BUSY=1; after DMA_REQ falls: one CE_R with GNT=00, then GNT=01.
REQ-033 RR=1, MAX_HOLD=4, both requesting continuously, IBUS_BUSY=0 -> GNT alternates in 4-window bursts separated by one idle CE_R.
REQ-034 CPU owner with CPU_LOCK=1 for 10 CE_R and DMA_REQ=1 -> GNT stays 01 and DMA_BUSY=1 throughout; GNT=10 within 2 CE_R after LOCK=0 and CPU_REQ=0.
REQ-035 DMA owner in a burst (IBUS_BURST=1, IBUS_BUSY=1 for 3 CE_R) with CPU requesting -> no switch until IBUS_BUSY=0.
REQ-036 Assert RST_N=0 mid-access with GNT=10 -> GNT=00 and IBUS_REQ=0 without a clock edge; EN=0 for 5 CE_R -> GNT and HOLD_CNT unchanged.
